ultrasonic_ranger_mc: RTL and testbench
=======================================

Name: ultrasonic_ranger_mc

Overview:
Parametrised multi-channel HC-SR04-class ranging engine. Fires trigger pulses on N_CH sensors in round-robin order and times each echo in microseconds. Converts echo width to centimetres by counting, with no divider. Adds timeout detection, enable control, inter-ping holdoff and a one-cycle result strobe. Sits between the sensor pins and the application logic (display, UART report, obstacle logic).

Parameters:
N_CH, 4, number of sensor channels (1..8)
TICKS_PER_US, 12, clk cycles per microsecond (12 MHz board clock)
TRIG_US, 10, trigger pulse width in microseconds
US_PER_CM, 58, echo microseconds per centimetre (round trip)
TIMEOUT_US, 30000, max microseconds from trigger fall to echo fall
HOLDOFF_US, 10000, idle microseconds after each result before the next channel fires
DIST_W, 16, width of the distance result

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  1 = keep scanning; 0 = stop after the current channel completes
echo  in  N_CH  raw echo inputs, asynchronous to clk
trig  out  N_CH  trigger outputs, at most one bit high at a time
busy  out  1  high whenever the FSM is not in IDLE
dist_valid  out  1  one-cycle strobe: result fields are valid
dist_ch  out  $clog2(N_CH) (min 1)  channel of the result
dist_cm  out  DIST_W  distance in cm, floor(echo_us / US_PER_CM)
dist_timeout  out  1  result is a timeout; dist_cm is all-ones

Behaviour:
- Reset is asynchronous: trig=0, busy=0, dist_valid=0, dist_ch=0, dist_cm=0, dist_timeout=0. The FSM goes to IDLE, the channel index to 0, and all counters and synchronisers to 0. Reset mid-ping drops trig immediately, and no result is emitted.
- Echo synchronisation:
  - Each echo bit passes through a 2-flop synchroniser (echo_s).
  - Edge detection compares echo_s with its previous value.
  - Pin-to-FSM latency is 2 cycles.
- Microsecond prescaler:
  - Counts 0..TICKS_PER_US-1.
  - It is cleared on every state transition.
  - us_tick is asserted when the counter equals TICKS_PER_US-1.
- FSM states and transitions:
  - IDLE: if enable=1, go to TRIG with the current channel.
  - TRIG: trig[ch]=1 for exactly TRIG_US*TICKS_PER_US cycles, then go to WAIT_RISE. trig is registered.
  - WAIT_RISE:
    - Waits for a rising edge of echo_s[ch].
    - An echo already high on entry is not a rising edge; the FSM waits for it to go low and then high again.
    - The timeout counter (us) runs from entry.
    - On a rising edge, go to MEASURE.
    - If the timeout counter reaches TIMEOUT_US, go to REPORT with the timeout flag set.
  - MEASURE:
    - The timeout counter keeps running.
    - A sub-counter counts us_ticks 0..US_PER_CM-1. On wrap, cm_cnt increments; cm_cnt saturates at 2^DIST_W-2.
    - On falling edge of echo_s[ch], go to REPORT (normal).
    - If the timeout counter reaches TIMEOUT_US first, go to REPORT with timeout=1.
  - REPORT: one cycle.
    - dist_valid=1, dist_ch=ch.
    - dist_cm=cm_cnt, or all-ones on timeout.
    - dist_timeout set accordingly.
    - Go to HOLDOFF.
  - HOLDOFF:
    - Wait HOLDOFF_US microseconds.
    - Then advance ch: ch+1, wrapping from N_CH-1 to 0.
    - If enable=1, go to TRIG; else go to IDLE.
- Enable rules: enable is sampled only in IDLE and at HOLDOFF exit. Deasserting it mid-ping never truncates a ping, a result or a holdoff.
- Output register rules:
  - dist_ch, dist_cm and dist_timeout hold their values until the next REPORT.
  - dist_valid is high for exactly 1 cycle per ping.
- Counter widths: sized by $clog2 of the parameter maxima. The timeout counter must not wrap before TIMEOUT_US.
- Simultaneous events: if the echo falling edge and the timeout occur in the same cycle, the falling edge wins (normal result).
- Echo activity on non-selected channels is ignored.
- Exactly one result is produced per ping, timeout or not.

Decomposition:
- Package ultrasonic_pkg holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF)
  - the default timing constants (TICKS_PER_US, US_PER_CM, TRIG_US, TIMEOUT_US)
  - the DIST_ALL_ONES localparam helper
- One sub-module: echo_sync_edge (per bit: 2-flop synchroniser, rise/fall pulses, async reset), instantiated N_CH times via generate.
- The FSM, prescaler and counters live in the top module.

Test Plan:
Bench parameters: TICKS_PER_US=2, N_CH=2, TRIG_US=10, US_PER_CM=58, TIMEOUT_US=3000, HOLDOFF_US=100.
1. Reset then enable=1 -> trig[0] high exactly 20 cycles, trig[1] stays 0, busy=1 from the cycle after enable.
2. Channel 0 echo high for 580 us (1160 cycles) -> one dist_valid, dist_ch=0, dist_cm=10, dist_timeout=0. A 579 us echo -> dist_cm=9.
3. Channel 1 echo never rises -> REPORT 3000 us after trig fall with dist_ch=1, dist_timeout=1, dist_cm=16'hFFFF. The next trig is on channel 0 after 100 us holdoff.
4. echo[0] held high before the trigger, falls 50 us after trig fall, rises 100 us after trig fall, and stays high 116 us -> the stale high is ignored, and the measurement gives dist_cm=2.
5. enable dropped during MEASURE -> the current result is still reported, holdoff completes, FSM returns to IDLE, busy=0, and no further trig.
6. rst asserted mid-TRIG and mid-MEASURE -> trig=0 in the same cycle (async), no dist_valid. After release with enable=1, the first trig is on channel 0.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing constants for the multi-channel ultrasonic ranger.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    HOLDOFF
  } state_t;

  localparam int DEF_TICKS_PER_US = 12;
  localparam int DEF_US_PER_CM    = 58;
  localparam int DEF_TRIG_US      = 10;
  localparam int DEF_TIMEOUT_US   = 30000;
  localparam int DEF_HOLDOFF_US   = 10000;
  localparam int DEF_DIST_W       = 16;

  // Distance code reported on a timeout at the default result width.
  localparam logic [DEF_DIST_W-1:0] DIST_ALL_ONES = '1;

  // Largest of three microsecond limits; sizes the shared microsecond counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Per-bit echo synchroniser: two flops into the clk domain plus edge pulses.
module echo_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_echo,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser followed by a previous-value flop for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_echo;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin HC-SR04-class ranging engine: trigger, time the echo, count centimetres.
module ultrasonic_ranger_mc
  import ultrasonic_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int TRIG_US      = DEF_TRIG_US,
  parameter int US_PER_CM    = DEF_US_PER_CM,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US   = DEF_HOLDOFF_US,
  parameter int DIST_W       = DEF_DIST_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic [N_CH-1:0]                         echo,
  output logic [N_CH-1:0]                         trig,
  output logic                                    busy,
  output logic                                    dist_valid,
  output logic [$clog2((N_CH > 1) ? N_CH : 2)-1:0] dist_ch,
  output logic [DIST_W-1:0]                       dist_cm,
  output logic                                    dist_timeout
);

  localparam int CH_W  = $clog2((N_CH > 1) ? N_CH : 2);
  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int US_W  = $clog2(max3(TIMEOUT_US, HOLDOFF_US, TRIG_US) + 1);
  localparam int SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam logic [DIST_W-1:0] CM_ONES = '1;
  localparam logic [DIST_W-1:0] CM_SAT  = CM_ONES - 1'b1;

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [PRE_W-1:0]  r_presc;
  logic [US_W-1:0]   r_us, w_us_nxt;
  logic [SUB_W-1:0]  r_sub, w_sub_nxt;
  logic [DIST_W-1:0] r_cm, w_cm_nxt;
  logic              w_timeout;
  logic [N_CH-1:0]   w_trig_nxt;
  logic [N_CH-1:0]   w_rise, w_fall;
  logic              w_rise_sel, w_fall_sel, w_us_tick;

  logic [N_CH-1:0]   r_trig;
  logic              r_busy, r_valid, r_dto;
  logic [CH_W-1:0]   r_dch;
  logic [DIST_W-1:0] r_dcm;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    echo_sync_edge u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_echo(echo[g]),
      .o_rise(w_rise[g]),
      .o_fall(w_fall[g])
    );
  end

  // Only the channel currently being pinged can move the FSM.
  assign w_rise_sel = w_rise[r_ch];
  assign w_fall_sel = w_fall[r_ch];
  assign w_us_tick  = (r_presc == PRE_W'(TICKS_PER_US - 1));

  // Next-state, counter and trigger decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_us_nxt    = r_us;
    w_sub_nxt   = r_sub;
    w_cm_nxt    = r_cm;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        w_us_nxt = '0;
        if (enable) w_state_nxt = TRIG;
      end
      TRIG: begin
        if (w_us_tick) begin
          if (r_us == US_W'(TRIG_US - 1)) begin
            w_state_nxt = WAIT_RISE;
            w_us_nxt    = '0;
          end else begin
            w_us_nxt = r_us + 1'b1;
          end
        end
      end
      WAIT_RISE: begin
        // An echo already high here produces no rise pulse, so a stale high is skipped.
        if (w_us_tick) w_us_nxt = r_us + 1'b1;
        if (w_rise_sel) begin
          w_state_nxt = MEASURE;
          w_sub_nxt   = '0;
          w_cm_nxt    = '0;
        end else if (w_us_tick && (r_us == US_W'(TIMEOUT_US - 1))) begin
          w_state_nxt = REPORT;
          w_timeout   = 1'b1;
        end
      end
      MEASURE: begin
        if (w_us_tick) begin
          w_us_nxt = r_us + 1'b1;
          if (r_sub == SUB_W'(US_PER_CM - 1)) begin
            w_sub_nxt = '0;
            if (r_cm != CM_SAT) w_cm_nxt = r_cm + 1'b1;
          end else begin
            w_sub_nxt = r_sub + 1'b1;
          end
        end
        // The falling edge wins over a timeout landing in the same cycle.
        if (w_fall_sel) begin
          w_state_nxt = REPORT;
        end else if (w_us_tick && (r_us == US_W'(TIMEOUT_US - 1))) begin
          w_state_nxt = REPORT;
          w_timeout   = 1'b1;
        end
      end
      REPORT: begin
        w_state_nxt = HOLDOFF;
        w_us_nxt    = '0;
      end
      HOLDOFF: begin
        if (w_us_tick) begin
          if (r_us == US_W'(HOLDOFF_US - 1)) begin
            w_ch_nxt    = (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + 1'b1;
            w_state_nxt = enable ? TRIG : IDLE;
            w_us_nxt    = '0;
          end else begin
            w_us_nxt = r_us + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_trig_nxt = '0;
    if (w_state_nxt == TRIG) w_trig_nxt[w_ch_nxt] = 1'b1;
  end

  // FSM state, channel index, prescaler (restarted on every state change) and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_presc <= '0;
      r_us    <= '0;
      r_sub   <= '0;
      r_cm    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_us    <= w_us_nxt;
      r_sub   <= w_sub_nxt;
      r_cm    <= w_cm_nxt;
      if ((w_state_nxt != r_state) || w_us_tick) r_presc <= '0;
      else                                       r_presc <= r_presc + 1'b1;
    end
  end

  // Registered outputs; result fields load on entry to REPORT and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_dch   <= '0;
      r_dcm   <= '0;
      r_dto   <= 1'b0;
    end else begin
      r_trig  <= w_trig_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_valid <= (w_state_nxt == REPORT);
      if (w_state_nxt == REPORT) begin
        r_dch <= r_ch;
        r_dcm <= w_timeout ? CM_ONES : w_cm_nxt;
        r_dto <= w_timeout;
      end
    end
  end

  assign trig         = r_trig;
  assign busy         = r_busy;
  assign dist_valid   = r_valid;
  assign dist_ch      = r_dch;
  assign dist_cm      = r_dcm;
  assign dist_timeout = r_dto;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed bench for ultrasonic_ranger_mc: table of pings plus reset/enable sequences.
module tb_ultrasonic_ranger_mc;

  localparam int N_CH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  echo;
  logic [1:0]  trig;
  logic        busy;
  logic        dist_valid;
  logic [0:0]  dist_ch;
  logic [15:0] dist_cm;
  logic        dist_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ch;       // channel expected to fire
    int          pre;      // echo held high from before the trigger until this cycle
    int          d;        // echo rise, cycles after trig fall
    int          w;        // echo high width in cycles (0 = never rises)
    int          noise;    // toggle the other channel's echo meanwhile
    int          drop_at;  // cycle after trig fall at which enable drops (-1 = never)
    logic [15:0] cm;
    logic        to;
    int          lat;      // cycles from trig fall to dist_valid (-1 = unchecked)
  } vec_t;

  vec_t vecs[8];

  ultrasonic_ranger_mc #(
    .N_CH(N_CH), .TICKS_PER_US(2), .TRIG_US(10), .US_PER_CM(58),
    .TIMEOUT_US(3000), .HOLDOFF_US(100), .DIST_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig), .busy(busy),
    .dist_valid(dist_valid), .dist_ch(dist_ch), .dist_cm(dist_cm), .dist_timeout(dist_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ping(input vec_t v, input int exp_gap);
    int n, wd, c;
    logic ok;
    logic [1:0] exp_trig;
    exp_trig = 2'b01 << v.ch;
    echo[v.ch] = (v.pre > 0);
    n = 0;
    while (trig == 2'b00 && n < 2000) begin step(); n++; end
    chk("trig_gap", n, exp_gap);
    wd = 0;
    ok = 1'b1;
    while (trig != 2'b00 && wd < 200) begin
      if (trig !== exp_trig) ok = 1'b0;
      step();
      wd++;
    end
    chk("trig_width", wd, 20);
    chk("trig_channel", ok, 1);
    for (c = 0; c < 8000; c++) begin
      if (dist_valid) break;
      echo[v.ch] = (c < v.pre) || (c >= v.d && c < v.d + v.w);
      if (v.noise != 0) echo[1 - v.ch] = c[2];
      if (c == v.drop_at) enable = 1'b0;
      step();
    end
    echo = 2'b00;
    chk("valid_seen", dist_valid, 1);
    if (v.lat >= 0) chk("latency", c, v.lat);
    chk("dist_ch", dist_ch, v.ch);
    chk("dist_cm", dist_cm, v.cm);
    chk("dist_timeout", dist_timeout, v.to);
    chk("busy_report", busy, 1);
    step();
    chk("valid_one_cycle", dist_valid, 0);
    chk("dist_cm_held", dist_cm, v.cm);
  endtask

  initial begin
    int n;
    logic seen;
    //          ch pre  d    w    noise drop  cm         to    lat
    vecs[0] = '{0, 0,   20,  1160, 0,   -1,  16'd10,    1'b0, 1183};
    vecs[1] = '{1, 0,   0,   0,    0,   -1,  16'hFFFF,  1'b1, 6000};
    vecs[2] = '{0, 0,   20,  1158, 0,   -1,  16'd9,     1'b0, 1181};
    vecs[3] = '{1, 0,   10,  116,  1,   -1,  16'd1,     1'b0, 129};
    vecs[4] = '{0, 0,   0,   2,    0,   -1,  16'd0,     1'b0, 5};
    vecs[5] = '{1, 0,   40,  7000, 0,   -1,  16'hFFFF,  1'b1, -1};
    vecs[6] = '{0, 100, 200, 232,  0,   -1,  16'd2,     1'b0, 435};
    vecs[7] = '{1, 0,   20,  580,  0,   30,  16'd5,     1'b0, 603};

    rst = 1'b1; enable = 1'b0; echo = 2'b00;
    repeat (3) step();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", dist_valid, 0);
    chk("rst_ch", dist_ch, 0);
    chk("rst_cm", dist_cm, 0);
    chk("rst_timeout", dist_timeout, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    step();
    chk("en_busy", busy, 1);
    chk("en_trig", trig, 2'b01);

    for (int i = 0; i < 8; i++) ping(vecs[i], (i == 0) ? 0 : 200);

    // Enable dropped mid-measure: holdoff finishes, then the engine parks in IDLE.
    repeat (199) step();
    chk("holdoff_busy", busy, 1);
    step();
    chk("idle_after_drop", busy, 0);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (trig != 2'b00 || busy || dist_valid) seen = 1'b1;
      step();
    end
    chk("stays_idle", seen, 0);

    // Reset mid-TRIG on channel 1.
    enable = 1'b1;
    ping('{0, 0, 0, 2, 0, -1, 16'd0, 1'b0, 5}, 1);
    n = 0;
    while (trig == 2'b00 && n < 500) begin step(); n++; end
    chk("trig_ch1_before_rst", trig, 2'b10);
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_trig_async", trig, 0);
    chk("rst_busy_async", busy, 0);
    repeat (3) step();
    chk("rst_no_valid", dist_valid, 0);
    rst = 1'b0;
    step();
    chk("first_trig_ch0", trig, 2'b01);

    // Reset mid-MEASURE on channel 0: no result, outputs cleared.
    n = 0;
    while (trig != 2'b00 && n < 100) begin step(); n++; end
    echo[0] = 1'b1;
    repeat (100) step();
    #2 rst = 1'b1;
    #1;
    chk("rstm_trig", trig, 0);
    chk("rstm_valid", dist_valid, 0);
    chk("rstm_cm", dist_cm, 0);
    chk("rstm_timeout", dist_timeout, 0);
    echo = 2'b00;
    enable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (dist_valid || trig != 2'b00 || busy) seen = 1'b1;
      step();
    end
    chk("rstm_quiet", seen, 0);
    enable = 1'b1;
    step();
    chk("rstm_first_trig_ch0", trig, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
